// File: rtl/pp_pipeline_accel_fifo_flex.sv
// pp_pipeline_accel_fifo_flex
//   Parametrised shift-register FIFO for stream channels between
//   pp_pipeline_accel dataflow processes. Show-ahead: the head word is
//   valid on if_dout whenever if_empty_n=1.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   if_flush              : synchronous discard of all contents
//   if_err_clr            : clears sticky overflow/underflow flags
//   if_write_ce/if_write  : write enable/request, data on if_din
//   if_full_n             : space available
//   if_read_ce/if_read    : read enable/request (pops head)
//   if_dout, if_empty_n   : head word and data-available
//   if_num_data_valid     : current occupancy
//   if_fifo_cap           : constant DEPTH
//   if_almost_full/empty  : registered threshold flags
//   if_overflow/underflow : sticky error flags
module pp_pipeline_accel_fifo_flex #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int AF_THRESH  = 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_flush,
    input  logic                  if_err_clr,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_overflow,
    output logic                  if_underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  unf_set;

    assign wr_acc  = if_write & if_write_ce & if_full_n;
    assign rd_acc  = if_read & if_read_ce & if_empty_n;
    assign ovf_set = if_write & if_write_ce & ~if_full_n & ~if_flush;
    assign unf_set = if_read & if_read_ce & ~if_empty_n & ~if_flush;

    always_comb begin
        cnt_nxt = cnt;
        if (if_flush)
            cnt_nxt = '0;
        else if (wr_acc && !rd_acc)
            cnt_nxt = cnt + CNT_ONE;
        else if (rd_acc && !wr_acc)
            cnt_nxt = cnt - CNT_ONE;
    end

    // Oldest word sits at the top of the occupied region of the shift register.
    always_comb begin
        head_addr = '0;
        if (cnt != '0)
            head_addr = ADDR_WIDTH'(cnt - CNT_ONE);
    end

    assign if_dout           = mem[head_addr];
    assign if_num_data_valid = cnt;
    assign if_fifo_cap       = CNT_DEPTH;

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && !if_flush && wr_acc) begin
            for (int unsigned i = DEPTH - 1; i > 0; i--)
                mem[i] <= mem[i-1];
            mem[0] <= if_din;
        end
    end

    // Flags are registered from cnt_nxt so they track cnt exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            if_empty_n      <= 1'b0;
            if_full_n       <= 1'b1;
            if_almost_full  <= 1'b0;
            if_almost_empty <= 1'b1;
            if_overflow     <= 1'b0;
            if_underflow    <= 1'b0;
        end else begin
            cnt             <= cnt_nxt;
            if_empty_n      <= (cnt_nxt != '0);
            if_full_n       <= (cnt_nxt != CNT_DEPTH);
            if_almost_full  <= (cnt_nxt >= CNT_AF);
            if_almost_empty <= (cnt_nxt <= CNT_AE);
            // Set has priority over clear.
            if (ovf_set)
                if_overflow <= 1'b1;
            else if (if_err_clr)
                if_overflow <= 1'b0;
            if (unf_set)
                if_underflow <= 1'b1;
            else if (if_err_clr)
                if_underflow <= 1'b0;
        end
    end

endmodule
